// File: rtl/axi4_mem_guard.sv
// axi4_mem_guard
//   AXI4 address-window guard in front of the memory address translator.
//   Bursts whose start address lies in [C_MEM_START_ADDR, C_MEM_START_ADDR+C_MEM_SIZE)
//   are forwarded with zero latency. All other bursts are terminated locally
//   with DECERR, so stray accesses never reach the memory controller.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   s_axi4_*       : upstream AXI4 slave port (from CPU)
//   m_axi4_*       : downstream AXI4 master port (to address translator)
module axi4_mem_guard #(
  parameter logic [33:0] C_MEM_START_ADDR  = 34'h80000000,
  parameter logic [33:0] C_MEM_SIZE        = 34'h40000000,
  parameter int          C_ID_BITS         = 4,
  parameter int          C_MAX_OUTSTANDING = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  // upstream AW
  input  logic                 s_axi4_aw_valid,
  output logic                 s_axi4_aw_ready,
  input  logic [C_ID_BITS-1:0] s_axi4_aw_id,
  input  logic [33:0]          s_axi4_aw_addr,
  input  logic [7:0]           s_axi4_aw_len,
  input  logic [2:0]           s_axi4_aw_size,
  input  logic [1:0]           s_axi4_aw_burst,
  input  logic                 s_axi4_aw_lock,
  input  logic [3:0]           s_axi4_aw_cache,
  input  logic [2:0]           s_axi4_aw_prot,
  input  logic [3:0]           s_axi4_aw_qos,
  // upstream W
  input  logic                 s_axi4_w_valid,
  output logic                 s_axi4_w_ready,
  input  logic [63:0]          s_axi4_w_data,
  input  logic [7:0]           s_axi4_w_strb,
  input  logic                 s_axi4_w_last,
  // upstream B
  output logic                 s_axi4_b_valid,
  input  logic                 s_axi4_b_ready,
  output logic [C_ID_BITS-1:0] s_axi4_b_id,
  output logic [1:0]           s_axi4_b_resp,
  // upstream AR
  input  logic                 s_axi4_ar_valid,
  output logic                 s_axi4_ar_ready,
  input  logic [C_ID_BITS-1:0] s_axi4_ar_id,
  input  logic [33:0]          s_axi4_ar_addr,
  input  logic [7:0]           s_axi4_ar_len,
  input  logic [2:0]           s_axi4_ar_size,
  input  logic [1:0]           s_axi4_ar_burst,
  input  logic                 s_axi4_ar_lock,
  input  logic [3:0]           s_axi4_ar_cache,
  input  logic [2:0]           s_axi4_ar_prot,
  input  logic [3:0]           s_axi4_ar_qos,
  // upstream R
  output logic                 s_axi4_r_valid,
  input  logic                 s_axi4_r_ready,
  output logic [C_ID_BITS-1:0] s_axi4_r_id,
  output logic [63:0]          s_axi4_r_data,
  output logic [1:0]           s_axi4_r_resp,
  output logic                 s_axi4_r_last,
  // downstream AW
  output logic                 m_axi4_aw_valid,
  input  logic                 m_axi4_aw_ready,
  output logic [C_ID_BITS-1:0] m_axi4_aw_id,
  output logic [33:0]          m_axi4_aw_addr,
  output logic [7:0]           m_axi4_aw_len,
  output logic [2:0]           m_axi4_aw_size,
  output logic [1:0]           m_axi4_aw_burst,
  output logic                 m_axi4_aw_lock,
  output logic [3:0]           m_axi4_aw_cache,
  output logic [2:0]           m_axi4_aw_prot,
  output logic [3:0]           m_axi4_aw_qos,
  // downstream W
  output logic                 m_axi4_w_valid,
  input  logic                 m_axi4_w_ready,
  output logic [63:0]          m_axi4_w_data,
  output logic [7:0]           m_axi4_w_strb,
  output logic                 m_axi4_w_last,
  // downstream B
  input  logic                 m_axi4_b_valid,
  output logic                 m_axi4_b_ready,
  input  logic [C_ID_BITS-1:0] m_axi4_b_id,
  input  logic [1:0]           m_axi4_b_resp,
  // downstream AR
  output logic                 m_axi4_ar_valid,
  input  logic                 m_axi4_ar_ready,
  output logic [C_ID_BITS-1:0] m_axi4_ar_id,
  output logic [33:0]          m_axi4_ar_addr,
  output logic [7:0]           m_axi4_ar_len,
  output logic [2:0]           m_axi4_ar_size,
  output logic [1:0]           m_axi4_ar_burst,
  output logic                 m_axi4_ar_lock,
  output logic [3:0]           m_axi4_ar_cache,
  output logic [2:0]           m_axi4_ar_prot,
  output logic [3:0]           m_axi4_ar_qos,
  // downstream R
  input  logic                 m_axi4_r_valid,
  output logic                 m_axi4_r_ready,
  input  logic [C_ID_BITS-1:0] m_axi4_r_id,
  input  logic [63:0]          m_axi4_r_data,
  input  logic [1:0]           m_axi4_r_resp,
  input  logic                 m_axi4_r_last
);

  localparam int            CW      = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {W_IDLE, W_ERR_DATA, W_ERR_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_ERR} r_state_t;

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic [CW-1:0]        aw_out, w_pend, ar_out;
  logic [C_ID_BITS-1:0] b_id_q, r_id_q;
  logic [7:0]           r_len_q, r_beat;

  // Subtraction is modulo 2^34; the >= guard keeps it from wrapping into range.
  function automatic logic in_win(input logic [33:0] a);
    return (a >= C_MEM_START_ADDR) && ((a - C_MEM_START_ADDR) < C_MEM_SIZE);
  endfunction

  wire aw_hit = in_win(s_axi4_aw_addr);
  wire ar_hit = in_win(s_axi4_ar_addr);

  // Non-handshake fields pass straight through.
  assign m_axi4_aw_id    = s_axi4_aw_id;
  assign m_axi4_aw_addr  = s_axi4_aw_addr;
  assign m_axi4_aw_len   = s_axi4_aw_len;
  assign m_axi4_aw_size  = s_axi4_aw_size;
  assign m_axi4_aw_burst = s_axi4_aw_burst;
  assign m_axi4_aw_lock  = s_axi4_aw_lock;
  assign m_axi4_aw_cache = s_axi4_aw_cache;
  assign m_axi4_aw_prot  = s_axi4_aw_prot;
  assign m_axi4_aw_qos   = s_axi4_aw_qos;
  assign m_axi4_w_data   = s_axi4_w_data;
  assign m_axi4_w_strb   = s_axi4_w_strb;
  assign m_axi4_w_last   = s_axi4_w_last;
  assign m_axi4_ar_id    = s_axi4_ar_id;
  assign m_axi4_ar_addr  = s_axi4_ar_addr;
  assign m_axi4_ar_len   = s_axi4_ar_len;
  assign m_axi4_ar_size  = s_axi4_ar_size;
  assign m_axi4_ar_burst = s_axi4_ar_burst;
  assign m_axi4_ar_lock  = s_axi4_ar_lock;
  assign m_axi4_ar_cache = s_axi4_ar_cache;
  assign m_axi4_ar_prot  = s_axi4_ar_prot;
  assign m_axi4_ar_qos   = s_axi4_ar_qos;

  wire m_aw_hs     = m_axi4_aw_valid && m_axi4_aw_ready;
  wire m_w_last_hs = m_axi4_w_valid && m_axi4_w_ready && s_axi4_w_last;
  wire m_b_hs      = m_axi4_b_valid && m_axi4_b_ready;
  wire m_ar_hs     = m_axi4_ar_valid && m_axi4_ar_ready;
  wire m_r_last_hs = m_axi4_r_valid && m_axi4_r_ready && m_axi4_r_last;
  wire aw_err_hs   = (w_state == W_IDLE) && s_axi4_aw_valid && s_axi4_aw_ready && !aw_hit;
  wire ar_err_hs   = (r_state == R_IDLE) && s_axi4_ar_valid && s_axi4_ar_ready && !ar_hit;
  wire r_err_hs    = (r_state == R_ERR) && s_axi4_r_ready;

  // Write path
  always_comb begin
    w_state_d       = w_state;
    s_axi4_aw_ready = 1'b0;
    m_axi4_aw_valid = 1'b0;
    s_axi4_w_ready  = 1'b0;
    m_axi4_w_valid  = 1'b0;
    s_axi4_b_valid  = m_axi4_b_valid;
    s_axi4_b_id     = m_axi4_b_id;
    s_axi4_b_resp   = m_axi4_b_resp;
    m_axi4_b_ready  = s_axi4_b_ready;
    case (w_state)
      W_IDLE: if (s_axi4_aw_valid) begin
        if (aw_hit) begin
          m_axi4_aw_valid = (aw_out != MAX_OUT);
          s_axi4_aw_ready = m_axi4_aw_ready && (aw_out != MAX_OUT);
        end else begin
          // Wait for forwarded writes to drain so the local B cannot collide.
          s_axi4_aw_ready = (aw_out == '0);
          if (aw_out == '0) w_state_d = W_ERR_DATA;
        end
      end
      W_ERR_DATA: begin
        s_axi4_w_ready = 1'b1;
        if (s_axi4_w_valid && s_axi4_w_last) w_state_d = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        s_axi4_b_valid = 1'b1;
        s_axi4_b_id    = b_id_q;
        s_axi4_b_resp  = 2'b11;
        m_axi4_b_ready = 1'b0;
        if (s_axi4_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_pend != '0 && w_state != W_ERR_DATA) begin
      m_axi4_w_valid = s_axi4_w_valid;
      s_axi4_w_ready = m_axi4_w_ready;
    end
  end

  // Read path
  always_comb begin
    r_state_d       = r_state;
    s_axi4_ar_ready = 1'b0;
    m_axi4_ar_valid = 1'b0;
    s_axi4_r_valid  = m_axi4_r_valid;
    s_axi4_r_id     = m_axi4_r_id;
    s_axi4_r_data   = m_axi4_r_data;
    s_axi4_r_resp   = m_axi4_r_resp;
    s_axi4_r_last   = m_axi4_r_last;
    m_axi4_r_ready  = s_axi4_r_ready;
    case (r_state)
      R_IDLE: if (s_axi4_ar_valid) begin
        if (ar_hit) begin
          m_axi4_ar_valid = (ar_out != MAX_OUT);
          s_axi4_ar_ready = m_axi4_ar_ready && (ar_out != MAX_OUT);
        end else begin
          s_axi4_ar_ready = (ar_out == '0);
          if (ar_out == '0) r_state_d = R_ERR;
        end
      end
      R_ERR: begin
        s_axi4_r_valid = 1'b1;
        s_axi4_r_id    = r_id_q;
        s_axi4_r_data  = '0;
        s_axi4_r_resp  = 2'b11;
        s_axi4_r_last  = (r_beat == r_len_q);
        m_axi4_r_ready = 1'b0;
        if (s_axi4_r_ready && r_beat == r_len_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_out  <= '0;
      w_pend  <= '0;
      ar_out  <= '0;
      b_id_q  <= '0;
      r_id_q  <= '0;
      r_len_q <= '0;
      r_beat  <= '0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      case ({m_aw_hs, m_b_hs})
        2'b10:   aw_out <= aw_out + 1'b1;
        2'b01:   aw_out <= aw_out - 1'b1;
        default: ;
      endcase
      case ({m_aw_hs, m_w_last_hs})
        2'b10:   w_pend <= w_pend + 1'b1;
        2'b01:   w_pend <= w_pend - 1'b1;
        default: ;
      endcase
      case ({m_ar_hs, m_r_last_hs})
        2'b10:   ar_out <= ar_out + 1'b1;
        2'b01:   ar_out <= ar_out - 1'b1;
        default: ;
      endcase
      if (aw_err_hs) b_id_q <= s_axi4_aw_id;
      if (ar_err_hs) begin
        r_id_q  <= s_axi4_ar_id;
        r_len_q <= s_axi4_ar_len;
        r_beat  <= '0;
      end else if (r_err_hs) begin
        r_beat  <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_guard.sv
module tb_axi4_mem_guard;
  localparam int IDW = 4;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic s_aw_valid = 0, s_aw_ready; logic [IDW-1:0] s_aw_id = 0; logic [33:0] s_aw_addr = 0;
  logic [7:0] s_aw_len = 0;
  logic s_w_valid = 0, s_w_ready, s_w_last = 0; logic [63:0] s_w_data = 0; logic [7:0] s_w_strb = 0;
  logic s_b_valid, s_b_ready = 0; logic [IDW-1:0] s_b_id; logic [1:0] s_b_resp;
  logic s_ar_valid = 0, s_ar_ready; logic [IDW-1:0] s_ar_id = 0; logic [33:0] s_ar_addr = 0;
  logic [7:0] s_ar_len = 0;
  logic s_r_valid, s_r_ready = 0, s_r_last; logic [IDW-1:0] s_r_id; logic [63:0] s_r_data;
  logic [1:0] s_r_resp;
  logic m_aw_valid, m_aw_ready = 0; logic [IDW-1:0] m_aw_id; logic [33:0] m_aw_addr;
  logic [7:0] m_aw_len; logic [2:0] m_aw_size, m_aw_prot; logic [1:0] m_aw_burst;
  logic m_aw_lock; logic [3:0] m_aw_cache, m_aw_qos;
  logic m_w_valid, m_w_ready = 0, m_w_last; logic [63:0] m_w_data; logic [7:0] m_w_strb;
  logic m_b_valid = 0, m_b_ready; logic [IDW-1:0] m_b_id = 0; logic [1:0] m_b_resp = 0;
  logic m_ar_valid, m_ar_ready = 0; logic [IDW-1:0] m_ar_id; logic [33:0] m_ar_addr;
  logic [7:0] m_ar_len; logic [2:0] m_ar_size, m_ar_prot; logic [1:0] m_ar_burst;
  logic m_ar_lock; logic [3:0] m_ar_cache, m_ar_qos;
  logic m_r_valid = 0, m_r_ready, m_r_last = 0; logic [IDW-1:0] m_r_id = 0;
  logic [63:0] m_r_data = 0; logic [1:0] m_r_resp = 0;

  axi4_mem_guard dut (
    .clk(clk), .reset(reset),
    .s_axi4_aw_valid(s_aw_valid), .s_axi4_aw_ready(s_aw_ready), .s_axi4_aw_id(s_aw_id),
    .s_axi4_aw_addr(s_aw_addr), .s_axi4_aw_len(s_aw_len), .s_axi4_aw_size(3'd3),
    .s_axi4_aw_burst(2'b01), .s_axi4_aw_lock(1'b0), .s_axi4_aw_cache(4'h3),
    .s_axi4_aw_prot(3'd0), .s_axi4_aw_qos(4'd0),
    .s_axi4_w_valid(s_w_valid), .s_axi4_w_ready(s_w_ready), .s_axi4_w_data(s_w_data),
    .s_axi4_w_strb(s_w_strb), .s_axi4_w_last(s_w_last),
    .s_axi4_b_valid(s_b_valid), .s_axi4_b_ready(s_b_ready), .s_axi4_b_id(s_b_id),
    .s_axi4_b_resp(s_b_resp),
    .s_axi4_ar_valid(s_ar_valid), .s_axi4_ar_ready(s_ar_ready), .s_axi4_ar_id(s_ar_id),
    .s_axi4_ar_addr(s_ar_addr), .s_axi4_ar_len(s_ar_len), .s_axi4_ar_size(3'd3),
    .s_axi4_ar_burst(2'b01), .s_axi4_ar_lock(1'b0), .s_axi4_ar_cache(4'h3),
    .s_axi4_ar_prot(3'd0), .s_axi4_ar_qos(4'd0),
    .s_axi4_r_valid(s_r_valid), .s_axi4_r_ready(s_r_ready), .s_axi4_r_id(s_r_id),
    .s_axi4_r_data(s_r_data), .s_axi4_r_resp(s_r_resp), .s_axi4_r_last(s_r_last),
    .m_axi4_aw_valid(m_aw_valid), .m_axi4_aw_ready(m_aw_ready), .m_axi4_aw_id(m_aw_id),
    .m_axi4_aw_addr(m_aw_addr), .m_axi4_aw_len(m_aw_len), .m_axi4_aw_size(m_aw_size),
    .m_axi4_aw_burst(m_aw_burst), .m_axi4_aw_lock(m_aw_lock), .m_axi4_aw_cache(m_aw_cache),
    .m_axi4_aw_prot(m_aw_prot), .m_axi4_aw_qos(m_aw_qos),
    .m_axi4_w_valid(m_w_valid), .m_axi4_w_ready(m_w_ready), .m_axi4_w_data(m_w_data),
    .m_axi4_w_strb(m_w_strb), .m_axi4_w_last(m_w_last),
    .m_axi4_b_valid(m_b_valid), .m_axi4_b_ready(m_b_ready), .m_axi4_b_id(m_b_id),
    .m_axi4_b_resp(m_b_resp),
    .m_axi4_ar_valid(m_ar_valid), .m_axi4_ar_ready(m_ar_ready), .m_axi4_ar_id(m_ar_id),
    .m_axi4_ar_addr(m_ar_addr), .m_axi4_ar_len(m_ar_len), .m_axi4_ar_size(m_ar_size),
    .m_axi4_ar_burst(m_ar_burst), .m_axi4_ar_lock(m_ar_lock), .m_axi4_ar_cache(m_ar_cache),
    .m_axi4_ar_prot(m_ar_prot), .m_axi4_ar_qos(m_ar_qos),
    .m_axi4_r_valid(m_r_valid), .m_axi4_r_ready(m_r_ready), .m_axi4_r_id(m_r_id),
    .m_axi4_r_data(m_r_data), .m_axi4_r_resp(m_r_resp), .m_axi4_r_last(m_r_last)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  int beat;

  initial begin
    #1;
    // Reset state
    do_reset(); #1;
    chk("rst_s_aw_ready", s_aw_ready, 0);
    chk("rst_s_ar_ready", s_ar_ready, 0);
    chk("rst_s_w_ready", s_w_ready, 0);
    chk("rst_s_b_valid", s_b_valid, 0);
    chk("rst_s_r_valid", s_r_valid, 0);
    chk("rst_m_aw_valid", m_aw_valid, 0);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_m_w_valid", m_w_valid, 0);
    tick();

    // Window edges (m_aw_ready low, so no handshake happens)
    s_aw_valid = 1; s_aw_addr = 34'h7FFFFFFF; #1;
    chk("edge_below_m_aw_valid", m_aw_valid, 0);
    s_aw_addr = 34'h80000000; #1;
    chk("edge_start_m_aw_valid", m_aw_valid, 1);
    s_aw_addr = 34'hBFFFFFFF; #1;
    chk("edge_last_m_aw_valid", m_aw_valid, 1);
    s_aw_addr = 34'h3_80000000; #1;
    chk("edge_high_m_aw_valid", m_aw_valid, 0);
    s_aw_valid = 0; tick();

    // Outstanding limit: 16 in-range ARs accepted, 17th blocked
    s_ar_valid = 1; s_ar_addr = 34'h80000040; m_ar_ready = 1;
    for (int i = 0; i < 16; i++) tick();
    chk("max_out_s_ar_ready", s_ar_ready, 0);
    chk("max_out_m_ar_valid", m_ar_valid, 0);
    s_ar_valid = 0; m_ar_ready = 0;
    do_reset();

    // Test 1: in-range write, 4 beats, B pass-through
    s_aw_valid = 1; s_aw_id = 5; s_aw_addr = 34'h80001000; s_aw_len = 3;
    m_aw_ready = 1; m_w_ready = 1; #1;
    chk("t1_m_aw_valid", m_aw_valid, 1);
    chk("t1_m_aw_addr", m_aw_addr, 34'h80001000);
    chk("t1_m_aw_len", m_aw_len, 3);
    chk("t1_s_aw_ready", s_aw_ready, 1);
    tick(); s_aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      s_w_valid = 1; s_w_data = 64'hA5A5_0000_0000_0000 | 64'(i); s_w_strb = 8'hFF;
      s_w_last = (i == 3); #1;
      chk("t1_m_w_valid", m_w_valid, 1);
      chk("t1_m_w_data", m_w_data, 64'hA5A5_0000_0000_0000 | 64'(i));
      chk("t1_m_w_last", m_w_last, (i == 3));
      chk("t1_s_w_ready", s_w_ready, 1);
      tick();
    end
    s_w_valid = 0; s_w_last = 0; #1;
    chk("t1_w_closed", s_w_ready, 0);
    m_b_valid = 1; m_b_id = 5; m_b_resp = 2'b00; s_b_ready = 1; #1;
    chk("t1_s_b_valid", s_b_valid, 1);
    chk("t1_s_b_id", s_b_id, 5);
    chk("t1_s_b_resp", s_b_resp, 0);
    chk("t1_m_b_ready", m_b_ready, 1);
    tick(); m_b_valid = 0; s_b_ready = 0;

    // Test 3: first byte past window -> DECERR write; ready=1 also shows aw_out==0
    s_aw_valid = 1; s_aw_id = 9; s_aw_addr = 34'hC0000000; s_aw_len = 0; #1;
    chk("t3_m_aw_valid", m_aw_valid, 0);
    chk("t3_s_aw_ready", s_aw_ready, 1);
    tick(); s_aw_valid = 0;
    s_w_valid = 1; s_w_last = 1; s_w_data = 64'h1234; #1;
    chk("t3_s_w_ready", s_w_ready, 1);
    chk("t3_m_w_valid", m_w_valid, 0);
    chk("t3_no_b_yet", s_b_valid, 0);
    tick(); s_w_valid = 0; s_w_last = 0;
    s_aw_valid = 1; s_aw_addr = 34'h80000000; s_aw_id = 1; #1;
    chk("t3_s_b_valid", s_b_valid, 1);
    chk("t3_s_b_id", s_b_id, 9);
    chk("t3_s_b_resp", s_b_resp, 2'b11);
    chk("t3_aw_blocked", s_aw_ready, 0);
    chk("t3_m_aw_blocked", m_aw_valid, 0);
    tick(); #1;
    chk("t3_b_held", s_b_valid, 1);
    s_aw_valid = 0; s_b_ready = 1; tick(); s_b_ready = 0; #1;
    chk("t3_b_done", s_b_valid, 0);
    m_aw_ready = 0; m_w_ready = 0;

    // Test 2: out-of-range read, len 7
    s_ar_valid = 1; s_ar_id = 3; s_ar_addr = 34'h00010000; s_ar_len = 7; m_ar_ready = 1; #1;
    chk("t2_m_ar_valid", m_ar_valid, 0);
    chk("t2_s_ar_ready", s_ar_ready, 1);
    tick(); s_ar_valid = 0; s_r_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_r_valid", s_r_valid, 1);
      chk("t2_r_id", s_r_id, 3);
      chk("t2_r_resp", s_r_resp, 2'b11);
      chk("t2_r_data", s_r_data, 0);
      chk("t2_r_last", s_r_last, (i == 7));
      tick();
    end
    #1; chk("t2_r_end", s_r_valid, 0);

    // Test 4: error AR waits for outstanding in-range read to finish
    s_r_ready = 0;
    s_ar_valid = 1; s_ar_id = 1; s_ar_addr = 34'h80000000; s_ar_len = 1; #1;
    chk("t4_m_ar_valid", m_ar_valid, 1);
    tick();
    s_ar_id = 2; s_ar_addr = 34'h00000100; s_ar_len = 0; #1;
    chk("t4_ar_blocked0", s_ar_ready, 0);
    tick(); #1;
    chk("t4_ar_blocked1", s_ar_ready, 0);
    m_r_valid = 1; m_r_id = 1; m_r_data = 64'hDEAD; m_r_last = 0; s_r_ready = 1; #1;
    chk("t4_pass_r_valid", s_r_valid, 1);
    chk("t4_pass_r_data", s_r_data, 64'hDEAD);
    chk("t4_m_r_ready", m_r_ready, 1);
    tick();
    m_r_last = 1; m_r_data = 64'hBEEF; #1;
    chk("t4_ar_blocked2", s_ar_ready, 0);
    chk("t4_pass_r_last", s_r_last, 1);
    tick(); m_r_valid = 0; m_r_last = 0; #1;
    chk("t4_ar_open", s_ar_ready, 1);
    tick(); s_ar_valid = 0; #1;
    chk("t4_err_valid", s_r_valid, 1);
    chk("t4_err_id", s_r_id, 2);
    chk("t4_err_last", s_r_last, 1);
    chk("t4_err_m_r_ready", m_r_ready, 0);
    tick(); #1;
    chk("t4_err_done", s_r_valid, 0);
    m_ar_ready = 0;

    // Test 5: error read len 2 with toggling ready
    s_r_ready = 0; s_ar_valid = 1; s_ar_id = 6; s_ar_addr = 34'h2_00000000; s_ar_len = 2;
    tick(); s_ar_valid = 0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 3; c++) begin
      s_r_ready = c[0]; #1;
      chk("t5_r_valid", s_r_valid, 1);
      chk("t5_r_id", s_r_id, 6);
      chk("t5_r_data", s_r_data, 0);
      chk("t5_r_last", s_r_last, (beat == 2));
      if (s_r_ready) beat++;
      tick();
    end
    s_r_ready = 0; #1;
    chk("t5_done", s_r_valid, 0);

    // Test 6: reset mid error read
    s_ar_valid = 1; s_ar_id = 4; s_ar_addr = 34'h00000000; s_ar_len = 7;
    tick(); s_ar_valid = 0; s_r_ready = 1;
    tick(); tick(); s_r_ready = 0; #1;
    chk("t6_mid_valid", s_r_valid, 1);
    reset = 1; tick(); reset = 0; #1;
    chk("t6_after_rst_valid", s_r_valid, 0);
    s_ar_valid = 1; s_ar_addr = 34'h00000000; #1;
    chk("t6_idle_err_ready", s_ar_ready, 1);
    s_ar_addr = 34'h80000000; m_ar_ready = 1; #1;
    chk("t6_idle_pass_ready", s_ar_ready, 1);
    chk("t6_idle_m_ar_valid", m_ar_valid, 1);
    s_ar_valid = 0; m_ar_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_mem_guard.md
Name: axi4_mem_guard

Overview:
- AXI4 address-window guard, directly upstream of the memory address-offset translator on the CPU-to-DDR path.
- Transactions whose start address falls inside [C_MEM_START_ADDR, C_MEM_START_ADDR+C_MEM_SIZE) are forwarded to the translator unmodified.
- All other transactions are terminated locally with DECERR, so stray CPU accesses never reach the memory controller and never hang the bus.

Parameters:
C_MEM_START_ADDR, 34'h80000000, base of the legal memory window
C_MEM_SIZE, 34'h40000000, window size in bytes; nonzero; START+SIZE <= 2^34
C_ID_BITS, 4, AXI ID width
C_MAX_OUTSTANDING, 16, max forwarded bursts in flight per direction; outstanding counters are clog2(C_MAX_OUTSTANDING+1) bits

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
s_axi4_aw_*  in/out  valid/ready + id[C_ID_BITS], addr[34], len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4]  upstream write-address channel
s_axi4_w_*  in/out  valid/ready + data[64], strb[8], last  upstream write-data channel
s_axi4_b_*  out/in  valid/ready + id[C_ID_BITS], resp[2]  upstream write-response channel
s_axi4_ar_*  in/out  same fields as AW  upstream read-address channel
s_axi4_r_*  out/in  valid/ready + id, data[64], resp[2], last  upstream read-data channel
m_axi4_{aw,w,b,ar,r}_*  mirror of s_*  (opposite directions)  downstream to the address translator; same widths

Behaviour:
- Decode: in_range = (addr >= C_MEM_START_ADDR) && (addr - C_MEM_START_ADDR < C_MEM_SIZE). Compute in 34 bits, unsigned. Only the burst start address is checked.
- Reset: all valid/ready outputs are 0, both FSMs are IDLE, all counters are 0, captured id and len are 0. A reset mid-burst abandons the burst with no further beats or responses.

Write path:
- FSM states: W_IDLE, W_ERR_DATA, W_ERR_RESP.
- aw_out counts forwarded AWs whose B is not yet returned: +1 on m AW handshake, -1 on m B handshake; both in the same cycle gives no change.
- w_pend counts forwarded AWs whose WLAST is not yet sent: +1 on m AW handshake, -1 on m W handshake with last.
- W_IDLE, in_range AW: m_aw_valid = s_aw_valid and s_aw_ready = m_aw_ready (combinational), gated off when aw_out == C_MAX_OUTSTANDING.
- W_IDLE, out-of-range AW: s_aw_ready = 1 only when aw_out == 0. On the handshake, capture id and go to W_ERR_DATA. m_aw_valid stays 0.
- W channel: forwarded only while w_pend > 0 (m_w_valid = s_w_valid, s_w_ready = m_w_ready); otherwise s_w_ready = 0, except in W_ERR_DATA.
- W_ERR_DATA: s_w_ready = 1 and beats are discarded. The beat with last=1 moves the FSM to W_ERR_RESP. The beat count is not checked; WLAST alone terminates.
- W_ERR_RESP: s_b_valid = 1, b_id = captured id, resp = 2'b11. The handshake returns the FSM to W_IDLE. No new AW is accepted before that.
- B from downstream passes through combinationally in all states. The local error B is only driven when aw_out == 0, so the two sources never collide.

Read path:
- FSM states: R_IDLE, R_ERR.
- ar_out: +1 on m AR handshake, -1 on m R handshake with last.
- R_IDLE, in_range AR: passes through, gated off when ar_out == C_MAX_OUTSTANDING.
- R_IDLE, out-of-range AR: s_ar_ready = 1 only when ar_out == 0. Capture id and len, clear the beat counter, go to R_ERR.
- R_ERR: s_r_valid = 1, id = captured, data = 0, resp = 2'b11, last = (beat == len).
- R_ERR beat counter: 8 bits, increments on each s R handshake. The handshake with last=1 returns the FSM to R_IDLE.
- R_ERR: s_ar_ready = 0 and m_r_ready = 0; no downstream R is outstanding in this state.
- R_IDLE: R passes through combinationally.

General:
- All non-handshake fields pass through unmodified.
- Read and write paths are fully independent; a simultaneous error read and error write are both serviced.
- Pass-through latency is 0 cycles. Error B appears 1 cycle after WLAST is accepted. The first error R beat appears 1 cycle after the AR handshake.

Test Plan:
- AW addr 0x80001000 len 3 + 4 W beats, m ready held 1 -> m sees the same addr/len/data; B id 5 resp 0 returned to s; aw_out returns to 0.
- AR addr 0x00010000 id 3 len 7 -> no m_ar_valid; exactly 8 s R beats id 3, resp 2'b11, data 0, last only on beat 8.
- AW addr 0xC0000000 (first byte past the window) len 0 + 1 W -> W discarded, B resp 2'b11 one cycle after WLAST; m_aw_valid never asserted.
- In-range AR with m_r withheld, then out-of-range AR -> s_ar_ready stays 0 until the downstream RLAST is accepted; then the error burst runs.
- Error read with s_r_ready toggling 1/0 every cycle, len 2 -> 3 beats, with valid and fields held stable during stalls.
- Assert reset mid error-read (after beat 2 of 8) -> next cycle s_r_valid = 0, FSM R_IDLE, s_ar_ready reflects the idle rules.
